shift_add_sequencer: RTL

//   Sequential controller/datapath for the shift-add multiplier. Holds the

---
 rtl/shift_add_sequencer.sv | 110 +++++++++++
 1 files changed

// File: rtl/shift_add_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : shift_add_sequencer
// Purpose  : Controller/datapath for an n-bit shift-add multiplier; drives an
//            external combinational adder and yields a 2n-bit product.
// Revision : 1.0 - initial release
// ============================================================================
module shift_add_sequencer #(
  parameter int n = 4
) (
  input  logic           clock,
  input  logic           n_reset,
  input  logic           start,
  input  logic [n-1:0]   multiplicand,
  input  logic [n-1:0]   multiplier,
  input  logic [n-1:0]   Sum,
  input  logic           C,
  output logic [n-1:0]   A,
  output logic [n-1:0]   M,
  output logic [2*n-1:0] product,
  output logic           busy,
  output logic           done
);

  localparam int               c_cw    = $clog2(n + 1);
  localparam logic [c_cw-1:0]  c_count = c_cw'(n);
  localparam logic [c_cw-1:0]  c_last  = c_cw'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADD   = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [n-1:0]      r_a;
  logic [n-1:0]      r_q;
  logic [n-1:0]      r_m;
  logic              r_carry;
  logic [c_cw-1:0]   r_count;
  logic [2*n-1:0]    r_product;

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_ADD;
      S_ADD:   w_next = S_SHIFT;
      S_SHIFT: w_next = (r_count == c_last) ? S_DONE : S_ADD;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_a       <= '0;
      r_q       <= '0;
      r_m       <= '0;
      r_carry   <= 1'b0;
      r_count   <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_m     <= multiplicand;
            r_q     <= multiplier;
            r_a     <= '0;
            r_carry <= 1'b0;
            r_count <= c_count;
          end
        end
        S_ADD: begin
          // {carry,A} is n+1 bits so the adder carry-out is never dropped
          if (r_q[0]) begin
            {r_carry, r_a} <= {C, Sum};
          end
        end
        S_SHIFT: begin
          r_a     <= {r_carry, r_a[n-1:1]};
          r_q     <= {r_a[0], r_q[n-1:1]};
          r_carry <= 1'b0;
          r_count <= r_count - 1'b1;
          if (r_count == c_last) begin
            r_product <= {r_carry, r_a, r_q[n-1:1]};
          end
        end
        default: ;
      endcase
    end
  end

  assign A       = r_a;
  assign M       = r_m;
  assign product = r_product;
  assign busy    = (r_state == S_ADD) || (r_state == S_SHIFT);
  assign done    = (r_state == S_DONE);

endmodule
`default_nettype wire
